dac_cic_interp: RTL and testbench

Transmit-side counterpart of the ADC decimation chain. It accepts low-rate signed samples qualified by `clk_vld_in` and interpolates them by R with a 3-stage CIC interpolator. A first-order error-feedback requantizer then reduces the result to a 5-bit signed code every `clk` for the DAC modulator. It sits between the transmit sample source and the 5-bit DAC core, mirroring the 5-bit input of the receive chain.

---
 rtl/dac_cic_interp_if.sv | 21 ++
 rtl/dac_cic_interp.sv | 99 +++++++++
 tb/tb_dac_cic_interp.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/dac_cic_interp_if.sv
// Sample-side bus of the transmit CIC interpolator: low-rate strobe/data in,
// per-clock 5-bit DAC code, primed flag and sticky rate-error flag out.
interface dac_cic_interp_if #(
  parameter int unsigned IW = 16
);
  logic                 clk_vld_in;
  logic signed [IW-1:0] dat_in;
  logic                 clk_vld_out;
  logic signed [4:0]    dat_out;
  logic                 rate_err;

  modport master (
    output clk_vld_in, dat_in,
    input  clk_vld_out, dat_out, rate_err
  );

  modport slave (
    input  clk_vld_in, dat_in,
    output clk_vld_out, dat_out, rate_err
  );
endinterface

// File: rtl/dac_cic_interp.sv
// 3-stage CIC interpolator (ratio 2^R_LOG2) followed by a first-order
// error-feedback requantizer producing a 5-bit signed DAC code every clock.
module dac_cic_interp #(
  parameter int unsigned IW     = 16,
  parameter int unsigned R_LOG2 = 6
) (
  input  logic           clk,
  input  logic           rstn,
  dac_cic_interp_if.slave bus
);

  localparam int unsigned AW = IW + 2 * R_LOG2;
  localparam int unsigned QS = AW - 5;
  localparam int unsigned R  = 1 << R_LOG2;
  localparam int unsigned CW = R_LOG2 + 1;

  logic signed [AW-1:0] x_ext;
  logic signed [AW-1:0] c1, c2, c3;
  logic signed [AW-1:0] d1, d2, d3;
  logic signed [AW-1:0] p;
  logic signed [AW-1:0] i1, i2, i3;
  logic [QS-1:0]        e;
  logic [QS-1:0]        e_nxt;
  logic signed [AW:0]   v;
  logic signed [5:0]    q;
  logic signed [4:0]    q_sat;
  logic                 q_in_range;
  logic [CW-1:0]        cnt;
  logic                 armed;
  logic                 rate_bad;
  logic [3:0]           first_sr;

  // Low-rate comb differences and requantizer arithmetic.
  always_comb begin
    x_ext      = {{(AW-IW){bus.dat_in[IW-1]}}, bus.dat_in};
    c1         = x_ext - d1;
    c2         = c1 - d2;
    c3         = c2 - d3;
    // e is a non-negative residue below one output LSB
    v          = {i3[AW-1], i3} + {{(AW+1-QS){1'b0}}, e};
    q          = v[AW:QS];
    q_in_range = (q[5] == q[4]);
    q_sat      = q[4:0];
    e_nxt      = v[QS-1:0];
    if (!q_in_range) begin
      q_sat = q[5] ? 5'b10000 : 5'b01111;
      e_nxt = '0;
    end
    rate_bad   = bus.clk_vld_in && armed && (cnt != CW'(R - 1));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d1              <= '0;
      d2              <= '0;
      d3              <= '0;
      p               <= '0;
      i1              <= '0;
      i2              <= '0;
      i3              <= '0;
      e               <= '0;
      cnt             <= '0;
      armed           <= 1'b0;
      first_sr        <= '0;
      bus.dat_out     <= '0;
      bus.clk_vld_out <= 1'b0;
      bus.rate_err    <= 1'b0;
    end else begin
      if (bus.clk_vld_in) begin
        d1 <= x_ext;
        d2 <= c1;
        d3 <= c2;
      end
      // zero-stuffing: comb output only on strobe cycles
      p  <= bus.clk_vld_in ? c3 : '0;
      i1 <= i1 + p;
      i2 <= i2 + i1;
      i3 <= i3 + i2;

      e           <= e_nxt;
      bus.dat_out <= q_sat;

      if (bus.clk_vld_in) begin
        cnt <= '0;
      end else if (cnt != CW'(R)) begin
        cnt <= cnt + CW'(1);
      end
      armed <= armed | bus.clk_vld_in;
      if (rate_bad) begin
        bus.rate_err <= 1'b1;
      end

      // first strobe walks down the same 4-stage latency as the data path
      first_sr        <= {first_sr[2:0], bus.clk_vld_in & ~armed};
      bus.clk_vld_out <= bus.clk_vld_out | first_sr[3];
    end
  end

endmodule

// File: tb/tb_dac_cic_interp.sv
// Scoreboard bench for dac_cic_interp: stimulus queues cycle-tagged
// expectations, a negedge monitor pops and compares them.
module tb_dac_cic_interp;

  localparam int unsigned IW     = 16;
  localparam int unsigned R_LOG2 = 6;

  typedef enum int {K_DAT, K_VLD, K_ERR, K_I3, K_CLR, K_SUM, K_REP} kind_t;
  typedef struct {
    int unsigned cyc;
    kind_t       kind;
    int          lo;
    int          hi;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  int unsigned ecnt = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  exp_t        sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  dac_cic_interp_if #(.IW(IW)) bus ();

  dac_cic_interp #(.IW(IW), .R_LOG2(R_LOG2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic do_check(input string nm, input int unsigned c, input int act,
                          input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0d expected=[%0d..%0d]", nm, c, act, lo, hi);
  endtask

  // Monitor: samples outputs mid-cycle and retires expectations tagged with this edge.
  initial begin
    int acc_sum;
    int acc_rep;
    int prev_d;
    int d;
    int act;
    acc_sum = 0;
    acc_rep = 0;
    prev_d  = 0;
    forever begin
      @(negedge clk);
      d = int'(bus.dat_out);
      acc_sum += d;
      if (d == prev_d) acc_rep++;
      prev_d = d;
      for (int i = int'(sbq.size()) - 1; i >= 0; i--) begin
        if (sbq[i].cyc == ecnt) begin
          act = 0;
          case (sbq[i].kind)
            K_DAT: act = d;
            K_VLD: act = int'(bus.clk_vld_out);
            K_ERR: act = int'(bus.rate_err);
            K_I3:  act = int'(dut.i3);
            K_SUM: act = acc_sum;
            K_REP: act = acc_rep;
            default: act = 0;
          endcase
          if (sbq[i].kind == K_CLR) begin
            acc_sum = d;
            acc_rep = 0;
          end else begin
            do_check(sbq[i].kind.name(), ecnt, act, sbq[i].lo, sbq[i].hi);
          end
          sbq.delete(i);
        end else if (sbq[i].cyc < ecnt) begin
          n_checks++;
          $display("FAIL stale_%s cyc=%0d actual=missed expected=sampled", sbq[i].kind.name(), sbq[i].cyc);
          sbq.delete(i);
        end
      end
    end
  end

  function automatic void push_exp(input kind_t kd, input int unsigned c, input int lo, input int hi);
    exp_t x;
    x.cyc  = c;
    x.kind = kd;
    x.lo   = lo;
    x.hi   = hi;
    sbq.push_back(x);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic drive_strobe(input int x);
    bus.clk_vld_in = 1'b1;
    bus.dat_in     = IW'(x);
    step();
    bus.clk_vld_in = 1'b0;
    bus.dat_in     = IW'($urandom);
  endtask

  task automatic stream(input int x, input int n);
    repeat (n) begin
      drive_strobe(x);
      idle(63);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle(3);
    rstn = 1'b1;
    idle(2);
  endtask

  initial begin
    int unsigned k;
    rstn           = 1'b1;
    bus.clk_vld_in = 1'b0;
    bus.dat_in     = '0;
    #2 rstn = 1'b0;

    // Reset held with strobes active: everything stays quiet.
    step();
    for (int i = 0; i < 6; i++) begin
      bus.clk_vld_in = 1'b1;
      bus.dat_in     = IW'(32767 - i);
      step();
      push_exp(K_DAT, ecnt, 0, 0);
      push_exp(K_VLD, ecnt, 0, 0);
      push_exp(K_ERR, ecnt, 0, 0);
    end
    bus.clk_vld_in = 1'b0;
    rstn = 1'b1;
    idle(2);

    // DC 16384 -> exactly 8 after settling; primed flag latency 4.
    k = ecnt + 1;
    push_exp(K_VLD, k + 3, 0, 0);
    push_exp(K_VLD, k + 4, 1, 1);
    push_exp(K_DAT, k + 3, 0, 0);
    for (int i = 0; i < 16; i++) push_exp(K_DAT, k + 200 + i, 8, 8);
    push_exp(K_VLD, k + 380, 1, 1);
    push_exp(K_ERR, k + 380, 0, 0);
    stream(16384, 6);
    do_reset();

    // 1024 -> half an LSB: strict 0/1 alternation.
    k = ecnt + 1;
    push_exp(K_CLR, k + 256, 0, 0);
    push_exp(K_SUM, k + 319, 32, 32);
    push_exp(K_REP, k + 319, 0, 0);
    push_exp(K_DAT, k + 256, 0, 1);
    push_exp(K_DAT, k + 257, 0, 1);
    push_exp(K_DAT, k + 300, 0, 1);
    stream(1024, 8);
    do_reset();

    // Full-scale positive, full-scale negative, then back to zero.
    k = ecnt + 1;
    for (int i = 0; i < 8; i++) begin
      push_exp(K_DAT, k + 256 + i, 15, 15);
      push_exp(K_DAT, k + 384 + 256 + i, -16, -16);
      push_exp(K_DAT, k + 768 + 256 + i, 0, 0);
    end
    stream(32767, 6);
    stream(-32768, 6);
    stream(0, 6);
    do_reset();

    // Spacing 64, 64, 63: flag rises on the short strobe and sticks.
    k = ecnt + 1;
    push_exp(K_ERR, k + 64, 0, 0);
    push_exp(K_ERR, k + 128, 0, 0);
    push_exp(K_ERR, k + 190, 0, 0);
    push_exp(K_ERR, k + 191, 1, 1);
    push_exp(K_ERR, k + 250, 1, 1);
    drive_strobe(100);
    idle(63);
    drive_strobe(100);
    idle(63);
    drive_strobe(100);
    idle(62);
    drive_strobe(100);
    idle(60);
    rstn = 1'b0;
    push_exp(K_ERR, ecnt, 0, 0);
    push_exp(K_VLD, ecnt, 0, 0);
    idle(2);
    rstn = 1'b1;
    idle(2);

    // First strobe after reset is unchecked; a short second one is flagged.
    k = ecnt + 1;
    push_exp(K_ERR, k, 0, 0);
    push_exp(K_ERR, k + 4, 0, 0);
    push_exp(K_ERR, k + 5, 1, 1);
    drive_strobe(5);
    idle(4);
    drive_strobe(5);
    idle(4);
    do_reset();

    // Impulse 2048: i3 follows (j+1)(j+2)/2*x, output sums to 64.
    k = ecnt + 1;
    push_exp(K_I3, k + 2, 0, 0);
    push_exp(K_I3, k + 3, 2048, 2048);
    push_exp(K_I3, k + 12, 112640, 112640);
    push_exp(K_I3, k + 66, 4259840, 4259840);
    push_exp(K_DAT, k + 3, 0, 0);
    push_exp(K_CLR, k + 4, 0, 0);
    push_exp(K_SUM, k + 203, 63, 65);
    drive_strobe(2048);
    idle(63);
    stream(0, 3);

    for (int t = 0; t < 400 && sbq.size() != 0; t++) step();
    while (sbq.size() != 0) begin
      n_checks++;
      $display("FAIL pending_%s cyc=%0d actual=unchecked expected=checked", sbq[0].kind.name(), sbq[0].cyc);
      void'(sbq.pop_front());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
